vga_grid_renderer: RTL and testbench

- Parametrised successor to the snake-game VGA controller.
- Generates VGA timing from configurable porch, sync and active values, and renders a block grid (walls, food, snake) into 8-bit RGB.
- Adds four things: a pixel-enable divider, frame-synchronous shadowing of the game-state inputs (no tearing), a variable snake length, and a blinking food block.
- Sits between the game-logic FSM and the VGA connector.

---
 rtl/vga_grid_renderer.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_vga_grid_renderer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer
// Generates VGA timing from configurable porch, sync and active widths. Draws a
// block grid of walls, food and snake pieces as 8-bit RGB.
// The game state is copied into shadow registers once per frame, so input
// changes never tear a frame. The food block can blink on a frame-count period.
// Output latency is two pixel enables after the pixel position is produced.

module vga_grid_renderer #(
    parameter int         H_ACTIVE     = 640,
    parameter int         H_FP         = 16,
    parameter int         H_SYNC       = 96,
    parameter int         H_BP         = 48,
    parameter int         V_ACTIVE     = 480,
    parameter int         V_FP         = 10,
    parameter int         V_SYNC       = 2,
    parameter int         V_BP         = 29,
    parameter logic       SYNC_POL     = 1'b0,
    parameter int         CLK_DIV      = 1,
    parameter int         BLOCK_W      = 40,
    parameter int         BLOCK_H      = 40,
    parameter int         GRID_W       = 16,
    parameter int         GRID_H       = 12,
    parameter int         NUM_PIECES   = 8,
    parameter int         BLINK_FRAMES = 16,
    parameter logic [7:0] COLOR_WALL   = 8'h92,
    parameter logic [7:0] COLOR_FOOD   = 8'hE0,
    parameter logic [7:0] COLOR_SNAKE  = 8'h1C,
    parameter logic [7:0] COLOR_EMPTY  = 8'h02,
    localparam int        XB           = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int        YB           = (GRID_H > 1) ? $clog2(GRID_H) : 1,
    localparam int        LB           = $clog2(NUM_PIECES + 1)
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [XB*NUM_PIECES-1:0]   packSnakeX,
    input  logic [YB*NUM_PIECES-1:0]   packSnakeY,
    input  logic [LB-1:0]              snakeLength,
    input  logic [XB-1:0]              foodX,
    input  logic [YB-1:0]              foodY,
    output logic [7:0]                 RGB,
    output logic                       HSync,
    output logic                       VSync,
    output logic                       FrameStart,
    output logic                       Active
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SXW      = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int SYW      = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    // bx/by keep counting through the blanking interval, so size them for the
    // whole line/frame rather than for the grid
    localparam int BX_MAX   = (H_TOTAL - 1) / BLOCK_W;
    localparam int BY_MAX   = (V_TOTAL - 1) / BLOCK_H;
    localparam int BXW      = (BX_MAX > 0) ? $clog2(BX_MAX + 1) : 1;
    localparam int BYW      = (BY_MAX > 0) ? $clog2(BY_MAX + 1) : 1;
    localparam int BFW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [DW-1:0]            div_cnt_reg;
    logic                     pen;

    logic [HW-1:0]            h_cnt_reg,  h_cnt_next;
    logic [VW-1:0]            v_cnt_reg,  v_cnt_next;
    logic [SXW-1:0]           sub_x_reg,  sub_x_next;
    logic [SYW-1:0]           sub_y_reg,  sub_y_next;
    logic [BXW-1:0]           bx_reg,     bx_next;
    logic [BYW-1:0]           by_reg,     by_next;
    logic                     h_end;
    logic                     v_end;
    logic                     at_origin;
    logic                     pix_active;
    logic                     hsync_raw;
    logic                     vsync_raw;

    logic [XB*NUM_PIECES-1:0] snake_x_reg;
    logic [YB*NUM_PIECES-1:0] snake_y_reg;
    logic [LB-1:0]            len_reg;
    logic [LB-1:0]            len_clamped;
    logic [XB-1:0]            food_x_reg;
    logic [YB-1:0]            food_y_reg;
    logic                     blink_phase;

    logic [BXW-1:0]           s1_bx_reg;
    logic [BYW-1:0]           s1_by_reg;
    logic                     s1_active_reg;
    logic                     s1_hsync_reg;
    logic                     s1_vsync_reg;

    logic [NUM_PIECES-1:0]    piece_hit;
    logic                     snake_hit;
    logic                     food_hit;
    logic                     wall_hit;
    logic                     in_grid;
    logic [7:0]               pixel_color;

    logic [7:0]               rgb_reg;
    logic                     hsync_reg;
    logic                     vsync_reg;
    logic                     active_reg;
    logic                     frame_start_reg;

    // ------------------------------------------------------------------
    // Pixel enable divider
    // ------------------------------------------------------------------
    assign pen = (div_cnt_reg == DW'(CLK_DIV - 1));

    // Count system clocks within one pixel period; pen fires on the last one
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_cnt_reg <= '0;
        end else if (pen) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Raster position and block index
    // ------------------------------------------------------------------
    assign h_end      = (h_cnt_reg == HW'(H_TOTAL - 1));
    assign v_end      = (v_cnt_reg == VW'(V_TOTAL - 1));
    assign at_origin  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign pix_active = (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
    assign hsync_raw  = ((int'(h_cnt_reg) >= HS_START) && (int'(h_cnt_reg) < HS_END))
                        ? SYNC_POL : ~SYNC_POL;
    assign vsync_raw  = ((int'(v_cnt_reg) >= VS_START) && (int'(v_cnt_reg) < VS_END))
                        ? SYNC_POL : ~SYNC_POL;

    // Next raster position; the block index is built from sub-counters so no divider is needed
    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        sub_x_next = sub_x_reg;
        sub_y_next = sub_y_reg;
        bx_next    = bx_reg;
        by_next    = by_reg;
        if (h_end) begin
            h_cnt_next = '0;
            sub_x_next = '0;
            bx_next    = '0;
            if (v_end) begin
                v_cnt_next = '0;
                sub_y_next = '0;
                by_next    = '0;
            end else begin
                v_cnt_next = v_cnt_reg + VW'(1);
                if (sub_y_reg == SYW'(BLOCK_H - 1)) begin
                    sub_y_next = '0;
                    by_next    = by_reg + BYW'(1);
                end else begin
                    sub_y_next = sub_y_reg + SYW'(1);
                end
            end
        end else begin
            h_cnt_next = h_cnt_reg + HW'(1);
            if (sub_x_reg == SXW'(BLOCK_W - 1)) begin
                sub_x_next = '0;
                bx_next    = bx_reg + BXW'(1);
            end else begin
                sub_x_next = sub_x_reg + SXW'(1);
            end
        end
    end

    // Raster counters advance once per pixel enable
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
            sub_x_reg <= '0;
            sub_y_reg <= '0;
            bx_reg    <= '0;
            by_reg    <= '0;
        end else if (pen) begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
            sub_x_reg <= sub_x_next;
            sub_y_reg <= sub_y_next;
            bx_reg    <= bx_next;
            by_reg    <= by_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame-synchronous shadowing of the game state
    // ------------------------------------------------------------------
    // Length above the slot count is treated as "all slots valid"
    assign len_clamped = (int'(snakeLength) > NUM_PIECES) ? LB'(NUM_PIECES) : snakeLength;

    // Capture the game state on the first pixel of each frame
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            snake_x_reg <= '0;
            snake_y_reg <= '0;
            len_reg     <= '0;
            food_x_reg  <= '0;
            food_y_reg  <= '0;
        end else if (pen && at_origin) begin
            snake_x_reg <= packSnakeX;
            snake_y_reg <= packSnakeY;
            len_reg     <= len_clamped;
            food_x_reg  <= foodX;
            food_y_reg  <= foodY;
        end
    end

    // Frame marker: one Clock wide, issued together with the shadow capture
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= pen && at_origin;
        end
    end

    // ------------------------------------------------------------------
    // Food blink phase
    // ------------------------------------------------------------------
    generate
        if (BLINK_FRAMES > 0) begin : g_blink
            logic [BFW-1:0] blink_cnt_reg;
            logic           phase_reg;

            // Count completed frames; flip the phase after every BLINK_FRAMES of them
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= 1'b0;
                end else if (pen && h_end && v_end) begin
                    if (blink_cnt_reg == BFW'(BLINK_FRAMES - 1)) begin
                        blink_cnt_reg <= '0;
                        phase_reg     <= ~phase_reg;
                    end else begin
                        blink_cnt_reg <= blink_cnt_reg + BFW'(1);
                    end
                end
            end

            assign blink_phase = phase_reg;
        end else begin : g_no_blink
            assign blink_phase = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: block position, active flag, raw syncs
    // ------------------------------------------------------------------
    // Register the raster-derived values for the current pixel
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_bx_reg     <= '0;
            s1_by_reg     <= '0;
            s1_active_reg <= 1'b0;
            s1_hsync_reg  <= ~SYNC_POL;
            s1_vsync_reg  <= ~SYNC_POL;
        end else if (pen) begin
            s1_bx_reg     <= bx_reg;
            s1_by_reg     <= by_reg;
            s1_active_reg <= pix_active;
            s1_hsync_reg  <= hsync_raw;
            s1_vsync_reg  <= vsync_raw;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour lookup
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIECES; gi++) begin : g_piece
            // A slot only counts when it lies below the shadowed length
            assign piece_hit[gi] = (LB'(gi) < len_reg)
                && (int'(snake_x_reg[gi*XB +: XB]) == int'(s1_bx_reg))
                && (int'(snake_y_reg[gi*YB +: YB]) == int'(s1_by_reg));
        end
    endgenerate

    assign snake_hit = |piece_hit;
    assign food_hit  = (int'(food_x_reg) == int'(s1_bx_reg))
                    && (int'(food_y_reg) == int'(s1_by_reg))
                    && !blink_phase;
    assign in_grid   = (int'(s1_bx_reg) < GRID_W) && (int'(s1_by_reg) < GRID_H);
    assign wall_hit  = (s1_bx_reg == '0) || (int'(s1_bx_reg) == GRID_W - 1)
                    || (s1_by_reg == '0) || (int'(s1_by_reg) == GRID_H - 1);

    // Colour priority: blank, off-grid, wall, food, snake, empty
    always_comb begin
        pixel_color = 8'h00;
        if (s1_active_reg && in_grid) begin
            if (wall_hit) begin
                pixel_color = COLOR_WALL;
            end else if (food_hit) begin
                pixel_color = COLOR_FOOD;
            end else if (snake_hit) begin
                pixel_color = COLOR_SNAKE;
            end else begin
                pixel_color = COLOR_EMPTY;
            end
        end
    end

    // Output register: colour and syncs leave together so they stay aligned
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rgb_reg    <= 8'h00;
            hsync_reg  <= ~SYNC_POL;
            vsync_reg  <= ~SYNC_POL;
            active_reg <= 1'b0;
        end else if (pen) begin
            rgb_reg    <= pixel_color;
            hsync_reg  <= s1_hsync_reg;
            vsync_reg  <= s1_vsync_reg;
            active_reg <= s1_active_reg;
        end
    end

    assign RGB        = rgb_reg;
    assign HSync      = hsync_reg;
    assign VSync      = vsync_reg;
    assign Active     = active_reg;
    assign FrameStart = frame_start_reg;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Testbench for vga_grid_renderer. It uses a scaled-down raster so that
// several whole frames fit in a short run.
// The driver applies random game states and directed game states. It pushes
// the expected output of each pixel enable into a queue.
// The monitor pops that queue on every pixel enable. On clocks that are not
// pixel enables, it checks that the outputs hold steady.

module tb_vga_grid_renderer;

    localparam int H_ACTIVE     = 32;
    localparam int H_FP         = 4;
    localparam int H_SYNC       = 6;
    localparam int H_BP         = 4;
    localparam int V_ACTIVE     = 24;
    localparam int V_FP         = 2;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 3;
    localparam logic SYNC_POL   = 1'b0;
    localparam int CLK_DIV      = 2;
    localparam int BLOCK_W      = 2;
    localparam int BLOCK_H      = 2;
    localparam int GRID_W       = 14;
    localparam int GRID_H       = 10;
    localparam int NUM_PIECES   = 8;
    localparam int BLINK_FRAMES = 2;
    localparam int XB           = 4;
    localparam int YB           = 4;
    localparam int LB           = 4;
    localparam logic [7:0] C_WALL  = 8'h92;
    localparam logic [7:0] C_FOOD  = 8'hE0;
    localparam logic [7:0] C_SNAKE = 8'h1C;
    localparam logic [7:0] C_EMPTY = 8'h02;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 46
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 31
    localparam int T       = H_TOTAL * V_TOTAL;                // pens per frame
    localparam int MAX_CLK = 60000;

    typedef struct packed {
        logic [XB*NUM_PIECES-1:0] px;
        logic [YB*NUM_PIECES-1:0] py;
        logic [LB-1:0]            len;
        logic [XB-1:0]            fx;
        logic [YB-1:0]            fy;
    } state_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [7:0]  rgb;
        logic        hs;
        logic        vs;
        logic        act;
        logic        fs;
    } exp_t;

    logic                     Clock;
    logic                     Reset;
    logic [XB*NUM_PIECES-1:0] packSnakeX;
    logic [YB*NUM_PIECES-1:0] packSnakeY;
    logic [LB-1:0]            snakeLength;
    logic [XB-1:0]            foodX;
    logic [YB-1:0]            foodY;
    logic [7:0]               RGB;
    logic                     HSync;
    logic                     VSync;
    logic                     FrameStart;
    logic                     Active;

    int     checks = 0;
    int     errors = 0;
    bit     running = 0;
    bit     pen_flag = 0;
    exp_t   exp_q[$];
    exp_t   last_exp;
    state_t st [0:7];

    vga_grid_renderer #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .CLK_DIV(CLK_DIV),
        .BLOCK_W(BLOCK_W), .BLOCK_H(BLOCK_H), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .NUM_PIECES(NUM_PIECES), .BLINK_FRAMES(BLINK_FRAMES),
        .COLOR_WALL(C_WALL), .COLOR_FOOD(C_FOOD), .COLOR_SNAKE(C_SNAKE), .COLOR_EMPTY(C_EMPTY)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .packSnakeX(packSnakeX),
        .packSnakeY(packSnakeY),
        .snakeLength(snakeLength),
        .foodX(foodX),
        .foodY(foodY),
        .RGB(RGB),
        .HSync(HSync),
        .VSync(VSync),
        .FrameStart(FrameStart),
        .Active(Active)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: what the screen should show for pixel number idx since reset
    function automatic exp_t model(input int idx);
        exp_t   e;
        state_t s;
        int     fr, pos, h, v, bx, by, n;
        bit     hit;
        fr  = idx / T;
        pos = idx % T;
        h   = pos % H_TOTAL;
        v   = pos / H_TOTAL;
        s   = st[fr];
        e.idx = idx;
        e.act = (h < H_ACTIVE) && (v < V_ACTIVE);
        e.hs  = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        e.vs  = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
        e.fs  = (((idx + 1) % T) == 0);
        e.rgb = 8'h00;
        if (e.act) begin
            bx = h / BLOCK_W;
            by = v / BLOCK_H;
            if (bx < GRID_W && by < GRID_H) begin
                n   = (int'(s.len) > NUM_PIECES) ? NUM_PIECES : int'(s.len);
                hit = 0;
                for (int i = 0; i < n; i++) begin
                    if (int'(s.px[i*XB +: XB]) == bx && int'(s.py[i*YB +: YB]) == by) hit = 1;
                end
                if (bx == 0 || bx == GRID_W - 1 || by == 0 || by == GRID_H - 1)
                    e.rgb = C_WALL;
                else if (int'(s.fx) == bx && int'(s.fy) == by && ((fr / BLINK_FRAMES) % 2 == 0))
                    e.rgb = C_FOOD;
                else if (hit)
                    e.rgb = C_SNAKE;
                else
                    e.rgb = C_EMPTY;
            end
        end
        return e;
    endfunction

    function automatic state_t cur_state();
        state_t s;
        s.px  = packSnakeX;
        s.py  = packSnakeY;
        s.len = snakeLength;
        s.fx  = foodX;
        s.fy  = foodY;
        return s;
    endfunction

    function automatic exp_t reset_entry(input bit fs);
        exp_t e;
        e.idx = 32'hFFFF_FFFF;
        e.rgb = 8'h00;
        e.hs  = ~SYNC_POL;
        e.vs  = ~SYNC_POL;
        e.act = 1'b0;
        e.fs  = fs;
        return e;
    endfunction

    task automatic randomize_state();
        for (int i = 0; i < NUM_PIECES; i++) begin
            packSnakeX[i*XB +: XB] = XB'($urandom_range(0, 15));
            packSnakeY[i*YB +: YB] = YB'($urandom_range(0, 15));
        end
        snakeLength = LB'($urandom_range(0, 15));
        foodX       = XB'($urandom_range(0, 15));
        foodY       = YB'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) begin
            packSnakeX[XB-1:0] = foodX;
            packSnakeY[YB-1:0] = foodY;
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (RGB !== 8'h00 || HSync !== ~SYNC_POL || VSync !== ~SYNC_POL
            || FrameStart !== 1'b0 || Active !== 1'b0) begin
            errors++;
            $display("FAIL %s got rgb=%02h hs=%b vs=%b fs=%b act=%b want rgb=00 hs=%b vs=%b fs=0 act=0",
                     name, RGB, HSync, VSync, FrameStart, Active, ~SYNC_POL, ~SYNC_POL);
        end
    endtask

    // Monitor: compare on each pixel enable, check stability in between
    always @(negedge Clock) begin
        if (running) begin
            if (pen_flag) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_queue got empty queue want an expected entry");
                end else begin
                    last_exp = exp_q.pop_front();
                    if (RGB !== last_exp.rgb || HSync !== last_exp.hs || VSync !== last_exp.vs
                        || Active !== last_exp.act || FrameStart !== last_exp.fs) begin
                        errors++;
                        $display("FAIL pixel idx=%0d got rgb=%02h hs=%b vs=%b act=%b fs=%b want rgb=%02h hs=%b vs=%b act=%b fs=%b",
                                 $signed(last_exp.idx), RGB, HSync, VSync, Active, FrameStart,
                                 last_exp.rgb, last_exp.hs, last_exp.vs, last_exp.act, last_exp.fs);
                    end
                end
            end else begin
                checks++;
                if (RGB !== last_exp.rgb || HSync !== last_exp.hs || VSync !== last_exp.vs
                    || Active !== last_exp.act || FrameStart !== 1'b0) begin
                    errors++;
                    $display("FAIL hold idx=%0d got rgb=%02h hs=%b vs=%b act=%b fs=%b want rgb=%02h hs=%b vs=%b act=%b fs=0",
                             $signed(last_exp.idx), RGB, HSync, VSync, Active, FrameStart,
                             last_exp.rgb, last_exp.hs, last_exp.vs, last_exp.act);
                end
            end
        end
    end

    int cyc;
    int total_clk;
    int run_phase;
    bit done;

    task automatic restart();
        Reset    = 1'b0;
        cyc      = 0;
        pen_flag = 0;
        exp_q.delete();
        exp_q.push_back(reset_entry(1'b1));
        last_exp = reset_entry(1'b0);
        running  = 1;
    endtask

    // Driver: stimulus plus expected-value generation
    initial begin
        int idx, fr, pos, h, v;
        Reset       = 1'b1;
        packSnakeX  = '0;
        packSnakeY  = '0;
        snakeLength = '0;
        foodX       = '0;
        foodY       = '0;
        total_clk   = 0;
        run_phase   = 0;
        done        = 0;
        last_exp    = reset_entry(1'b0);
        repeat (5) @(posedge Clock);
        #1;
        check_reset("reset_init");

        // Frame 0: three visible pieces, a fourth piece beyond the length, food at (8,7)
        snakeLength = 4'd3;
        for (int i = 0; i < NUM_PIECES; i++) begin
            packSnakeX[i*XB +: XB] = (i < 4) ? XB'(5 + i) : XB'(i);
            packSnakeY[i*YB +: YB] = (i < 4) ? YB'(5) : YB'(2);
        end
        foodX = 4'd8;
        foodY = 4'd7;
        restart();

        while (!done) begin
            @(posedge Clock);
            #1;
            cyc++;
            total_clk++;
            if (total_clk > MAX_CLK) begin
                checks++;
                errors++;
                $display("FAIL timeout got %0d clocks want run end before %0d", total_clk, MAX_CLK);
                done = 1;
            end else if (cyc % CLK_DIV == 0) begin
                idx = cyc / CLK_DIV - 1;
                fr  = idx / T;
                pos = idx % T;
                h   = pos % H_TOTAL;
                v   = pos / H_TOTAL;
                pen_flag = 1;
                if (pos == 0) begin
                    if (run_phase == 1 && fr == 3) begin
                        done = 1;
                    end else begin
                        st[fr] = cur_state();
                        $display("frame %0d run %0d captured len=%0d food=(%0d,%0d)",
                                 fr, run_phase, snakeLength, foodX, foodY);
                    end
                end
                if (!done) begin
                    exp_q.push_back(model(idx));
                    // mid-frame input changes must stay invisible until next frame
                    if (h == 0 && v == V_ACTIVE / 2) begin
                        if (fr == 0 && run_phase == 0) foodX = 4'd3;
                        else randomize_state();
                    end
                    // new game state during vertical back porch
                    if (h == 0 && v == V_TOTAL - 1 && !(fr == 0 && run_phase == 0))
                        randomize_state();
                    // reset in the middle of frame 5
                    if (run_phase == 0 && fr == 5 && v == V_ACTIVE / 2 + 2 && h == 10) begin
                        pen_flag = 0;
                        running  = 0;
                        Reset    = 1'b1;
                        #1;
                        check_reset("reset_mid");
                        randomize_state();
                        repeat (3) @(posedge Clock);
                        #1;
                        check_reset("reset_hold");
                        restart();
                        run_phase = 1;
                    end
                end
            end else begin
                pen_flag = 0;
            end
        end

        @(negedge Clock);
        #1;
        running = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
